// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin arbiter sharing a byte-wide memory read port for 16-bit word reads
module mem_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 2048,
  parameter int MEM_AW     = 11,
  parameter int MEM_WIDTH  = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          nrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [WORD_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic                          rd_err,
  output logic                          busy,
  output logic [MEM_AW-1:0]             mem_addr,
  output logic                          mem_rd_en,
  input  logic [MEM_WIDTH-1:0]          mem_data_in
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, CAPT} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  logic                   legal_q, legal_d;
  logic [MEM_WIDTH-1:0]   lo_q, lo_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     rd_valid_q, rd_valid_d;
  logic                   rd_err_q, rd_err_d;
  logic [WORD_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
  logic                   mem_rd_en_q, mem_rd_en_d;

  logic                   found;
  logic [PTR_W-1:0]       pick;
  int                     cand;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic                   pick_legal;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = PTR_W'(cand);
      end
    end
  end

  assign pick_addr  = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_legal = !pick_addr[0] && (32'(pick_addr) <= 32'(MEM_DEPTH - 2));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    addr_d      = addr_q;
    legal_d     = legal_q;
    lo_d        = lo_q;
    gnt_d       = '0;
    rd_valid_d  = '0;
    rd_err_d    = 1'b0;
    rd_data_d   = rd_data_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = mem_rd_en_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          addr_d      = pick_addr[MEM_AW-1:0];
          legal_d     = pick_legal;
          gnt_d       = NUM_REQ'(1) << pick;
          rr_ptr_d    = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + PTR_W'(1);
          mem_addr_d  = pick_addr[MEM_AW-1:0];
          mem_rd_en_d = pick_legal;
          state_d     = RD_LO;
        end
      end
      RD_LO: begin
        mem_addr_d = addr_q + MEM_AW'(1);
        state_d    = RD_HI;
      end
      RD_HI: begin
        lo_d        = mem_data_in;
        mem_rd_en_d = 1'b0;
        state_d     = CAPT;
      end
      CAPT: begin
        rd_data_d  = legal_q ? WORD_WIDTH'({mem_data_in, lo_q}) : '0;
        rd_valid_d = NUM_REQ'(1) << win_q;
        rd_err_d   = !legal_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      addr_q      <= '0;
      legal_q     <= 1'b0;
      lo_q        <= '0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      legal_q     <= legal_d;
      lo_q        <= lo_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      rd_data_q   <= rd_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
    end
  end

  assign gnt       = gnt_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - directed self-checking bench for mem_rd_arbiter
module tb_mem_rd_arbiter;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic [3:0]  req   = '0;
  logic [63:0] req_addr = '0;
  logic [3:0]  gnt;
  logic [15:0] rd_data;
  logic [3:0]  rd_valid;
  logic        rd_err;
  logic        busy;
  logic [10:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data_in;

  logic [7:0]  mem [0:2047];
  logic [7:0]  mem_q = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int valid_cnt = 0;

  mem_rd_arbiter dut (
    .clock       (clock),
    .nrst        (nrst),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_data_in (mem_data_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (mem_rd_en) mem_q <= mem[mem_addr];
  end
  assign mem_data_in = mem_q;

  always @(negedge clock) if (rd_valid != 4'b0) valid_cnt = valid_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_one(input int idx, input logic [15:0] a, input logic [15:0] exp_d,
                         input logic exp_err);
    logic [3:0]  oh;
    logic [10:0] a_lo;
    logic [10:0] a_hi;
    oh   = 4'b0001 << idx;
    a_lo = a[10:0];
    a_hi = a_lo + 11'd1;
    @(negedge clock);
    req[idx] = 1'b1;
    req_addr[idx*16 +: 16] = a;
    @(negedge clock);
    check("gnt", gnt, oh);
    check("busy_e0", busy, 1);
    check("mem_addr_lo", mem_addr, a_lo);
    check("mem_rd_en_e0", mem_rd_en, !exp_err);
    req[idx] = 1'b0;
    @(negedge clock);
    check("gnt_clr", gnt, 0);
    check("mem_addr_hi", mem_addr, a_hi);
    check("mem_rd_en_e1", mem_rd_en, !exp_err);
    @(negedge clock);
    check("mem_rd_en_e2", mem_rd_en, 0);
    check("rd_valid_early", rd_valid, 0);
    @(negedge clock);
    check("rd_valid", rd_valid, oh);
    check("rd_data", rd_data, exp_d);
    check("rd_err", rd_err, exp_err);
    check("busy_idle", busy, 0);
    @(negedge clock);
    check("rd_valid_clr", rd_valid, 0);
    check("rd_err_clr", rd_err, 0);
    check("rd_data_hold", rd_data, exp_d);
  endtask

  task automatic hold_reset();
    @(negedge clock);
    nrst = 1'b0;
    repeat (2) @(negedge clock);
    nrst = 1'b1;
  endtask

  initial begin
    logic [3:0]  g_vec [0:7];
    int          g_cyc [0:7];
    logic [3:0]  v_vec [0:7];
    logic [15:0] v_dat [0:7];
    logic [15:0] exp_w [0:3];
    int ng;
    int nv;
    int v0;

    for (int i = 0; i < 2048; i++) mem[i] = i[7:0] ^ 8'hA5;
    mem[11'h68A] = 8'h05; mem[11'h68B] = 8'h00;
    mem[11'h648] = 8'h34; mem[11'h649] = 8'h12;
    mem[11'h7FE] = 8'hCD; mem[11'h7FF] = 8'hAB;
    exp_w[0] = 16'hA4A5; exp_w[1] = 16'hA6A7; exp_w[2] = 16'hA0A1; exp_w[3] = 16'hA2A3;

    repeat (2) @(negedge clock);
    check("rst_gnt", gnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_busy", busy, 0);
    nrst = 1'b1;

    run_one(0, 16'h068A, 16'h0005, 1'b0);
    run_one(1, 16'h0648, 16'h1234, 1'b0);
    run_one(2, 16'h01C9, 16'h0000, 1'b1);
    run_one(3, 16'h07FF, 16'h0000, 1'b1);
    run_one(0, 16'h07FE, 16'hABCD, 1'b0);

    // All four requesters held high straight out of reset
    @(negedge clock);
    nrst = 1'b0;
    req = 4'hF;
    req_addr = {16'h0106, 16'h0104, 16'h0102, 16'h0100};
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    ng = 0; nv = 0;
    for (int k = 0; k < 60 && nv < 8; k++) begin
      @(negedge clock);
      if (gnt != 4'b0 && ng < 8) begin g_vec[ng] = gnt; g_cyc[ng] = cyc; ng++; end
      if (rd_valid != 4'b0 && nv < 8) begin v_vec[nv] = rd_valid; v_dat[nv] = rd_data; nv++; end
    end
    req = 4'h0;
    check("cont_nvalid", nv, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < ng) check("cont_gnt", g_vec[k], 4'b0001 << (k % 4));
      if (k < ng && k > 0) check("cont_spacing", g_cyc[k] - g_cyc[k-1], 4);
      if (k < nv) check("cont_valid", v_vec[k], 4'b0001 << (k % 4));
      if (k < nv) check("cont_data", v_dat[k], exp_w[k % 4]);
    end
    repeat (6) @(negedge clock);

    // Requester 2 held, requester 0 pulses once after requester 2's first grant
    nrst = 1'b0;
    req = 4'b0100;
    req_addr = {16'h0, 16'h0200, 16'h0, 16'h0200};
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    ng = 0;
    for (int k = 0; k < 40 && ng < 3; k++) begin
      @(negedge clock);
      if (gnt != 4'b0) begin
        g_vec[ng] = gnt;
        ng++;
        if (gnt == 4'b0100 && ng == 1) req[0] = 1'b1;
        if (gnt == 4'b0001) req[0] = 1'b0;
      end
    end
    req = 4'h0;
    check("fair_ngnt", ng, 3);
    if (ng > 0) check("fair_g0", g_vec[0], 4'b0100);
    if (ng > 1) check("fair_g1", g_vec[1], 4'b0001);
    if (ng > 2) check("fair_g2", g_vec[2], 4'b0100);
    repeat (6) @(negedge clock);

    // Reset while the high byte read is in flight
    req[1] = 1'b1;
    req_addr[31:16] = 16'h0648;
    @(negedge clock);
    check("mid_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    @(negedge clock);
    check("mid_busy", busy, 1);
    check("mid_rd_en", mem_rd_en, 1);
    nrst = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_rd_en", mem_rd_en, 0);
    check("mid_rst_busy", busy, 0);
    v0 = valid_cnt;
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_no_valid", valid_cnt, v0);
    run_one(3, 16'h0648, 16'h1234, 1'b0);
    check("mid_one_valid", valid_cnt, v0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
